// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the two-port RAM arbiter.
// The request bundle is sized to the package default widths.
package ram_arb_pkg;

  localparam int BAND_DEF      = 64;
  localparam int DEPTH_DEF     = 128;
  localparam int ADDR_W_DEF    = $clog2(DEPTH_DEF);
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  // The counter must be able to hold MAX_BURST itself, because it saturates there.
  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [BAND_DEF-1:0]   wdata;
  } port_req_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester's access channel into the arbiter.
// The requester drives the master side and the arbiter implements the slave side.
interface ram_port_arbiter_if #(
  parameter int BAND   = 64,
  parameter int ADDR_W = 7
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BAND-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [BAND-1:0]   rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/rr_burst_sel.sv
// Round-robin selector with bounded burst tenure.
// It holds owner, burst_cnt and last, and picks the port that drives the RAM this cycle.
module rr_burst_sel
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   a_req,
  input  logic   b_req,
  output owner_e sel
);

  localparam int               CNT_W   = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  owner_e           owner;
  owner_e           last;
  owner_e           last_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_nxt;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel = OWN_NONE;
    case (owner)
      OWN_A: begin
        if (a_req && (burst_cnt < MAX_CNT || !b_req)) sel = OWN_A;
        else if (b_req)                               sel = OWN_B;
        else if (a_req)                               sel = OWN_A;
      end
      OWN_B: begin
        if (b_req && (burst_cnt < MAX_CNT || !a_req)) sel = OWN_B;
        else if (a_req)                               sel = OWN_A;
        else if (b_req)                               sel = OWN_B;
      end
      default: begin
        if (a_req && b_req) sel = (last == OWN_A) ? OWN_B : OWN_A;
        else if (a_req)     sel = OWN_A;
        else if (b_req)     sel = OWN_B;
      end
    endcase

    burst_nxt = '0;
    if (sel == OWN_NONE)   burst_nxt = '0;
    else if (sel == owner) burst_nxt = (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
    else                   burst_nxt = CNT_W'(1);

    last_nxt = (sel == OWN_NONE) ? last : sel;
  end

  // NOTE: state registers use non-blocking assignments under an asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      burst_cnt <= '0;
      last      <= OWN_B;
    end else begin
      owner     <= sel;
      burst_cnt <= burst_nxt;
      last      <= last_nxt;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between ports A and B.
// It muxes the selected port onto the RAM and returns read data one cycle after the granted read.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int BAND      = BAND_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   a,
  ram_port_arbiter_if.slave   b,
  output logic                ram_wr,
  output logic                ram_rd,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [BAND-1:0]     ram_wdata,
  input  logic [BAND-1:0]     ram_rdata
);

  owner_e    sel;
  port_req_t a_bundle;
  port_req_t b_bundle;
  port_req_t sel_bundle;
  logic [1:0] rd_own;  // bit 0: port A read in flight, bit 1: port B read in flight

  rr_burst_sel #(.MAX_BURST(MAX_BURST)) u_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (a.req),
    .b_req (b.req),
    .sel   (sel)
  );

  assign a_bundle = '{req: a.req, we: a.we, addr: a.addr, wdata: a.wdata};
  assign b_bundle = '{req: b.req, we: b.we, addr: b.addr, wdata: b.wdata};

  // An all-zero bundle when nothing is selected keeps the RAM idle with a zero address and data.
  always_comb begin
    sel_bundle = '0;
    case (sel)
      OWN_A:   sel_bundle = a_bundle;
      OWN_B:   sel_bundle = b_bundle;
      default: sel_bundle = '0;
    endcase
  end

  assign ram_wr    = sel_bundle.req &  sel_bundle.we;
  assign ram_rd    = sel_bundle.req & ~sel_bundle.we;
  assign ram_addr  = sel_bundle.addr;
  assign ram_wdata = sel_bundle.wdata;

  assign a.gnt = (sel == OWN_A);
  assign b.gnt = (sel == OWN_B);

  // The owner of the read issued this cycle; reset drops any return still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_own <= 2'b00;
    else        rd_own <= {b.gnt & ~b.we, a.gnt & ~a.we};
  end

  assign a.rvalid = rd_own[0];
  assign b.rvalid = rd_own[1];
  assign a.rdata  = rd_own[0] ? ram_rdata : '0;
  assign b.rdata  = rd_own[1] ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM attached.
// Inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int BAND   = 64;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.BAND(BAND), .ADDR_W(ADDR_W)) a_if ();
  ram_port_arbiter_if #(.BAND(BAND), .ADDR_W(ADDR_W)) b_if ();

  logic              ram_wr;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [BAND-1:0]   ram_wdata;
  logic [BAND-1:0]   ram_rdata;

  ram_port_arbiter #(.BAND(BAND), .DEPTH(DEPTH), .MAX_BURST(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_if),
    .b         (b_if),
    .ram_wr    (ram_wr),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Registered-read RAM that returns zero after any cycle without a read.
  logic [BAND-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_rd ? mem[ram_addr] : '0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [BAND-1:0] wdata);
    a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [BAND-1:0] wdata);
    b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  // Invariants that must hold in every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("wr_rd_exclusive", {63'd0, ram_wr & ram_rd}, 64'd0);
      check("single_gnt", {63'd0, a_if.gnt & b_if.gnt}, 64'd0);
      check("gnt_needs_req", {63'd0, (a_if.gnt & ~a_if.req) | (b_if.gnt & ~b_if.req)}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_a;
    logic prev_a;
    prev_a = 1'b0;
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    drive_b(1'b0, 1'b0, 7'd0, 64'd0);
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    sample();
    check("rst_a_gnt",    {63'd0, a_if.gnt},    64'd0);
    check("rst_b_gnt",    {63'd0, b_if.gnt},    64'd0);
    check("rst_a_rvalid", {63'd0, a_if.rvalid}, 64'd0);
    check("rst_b_rvalid", {63'd0, b_if.rvalid}, 64'd0);
    check("rst_a_rdata",  a_if.rdata,           64'd0);
    check("rst_b_rdata",  b_if.rdata,           64'd0);
    check("rst_ram_wr",   {63'd0, ram_wr},      64'd0);
    check("rst_ram_rd",   {63'd0, ram_rd},      64'd0);
    rst_n = 1'b1;

    // A writes 5, then B reads 5
    next_cycle();
    drive_a(1'b1, 1'b1, 7'd5, 64'hDEAD_BEEF);
    sample();
    check("t1_a_gnt",     {63'd0, a_if.gnt}, 64'd1);
    check("t1_ram_wr",    {63'd0, ram_wr},   64'd1);
    check("t1_ram_addr",  {57'd0, ram_addr}, 64'd5);
    check("t1_ram_wdata", ram_wdata,         64'hDEAD_BEEF);

    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    drive_b(1'b1, 1'b0, 7'd5, 64'd0);
    sample();
    check("t1_b_gnt",     {63'd0, b_if.gnt},    64'd1);
    check("t1_a_gnt_off", {63'd0, a_if.gnt},    64'd0);
    check("t1_ram_rd",    {63'd0, ram_rd},      64'd1);
    check("t1_wr_no_rv",  {63'd0, a_if.rvalid}, 64'd0);

    next_cycle();
    drive_b(1'b0, 1'b0, 7'd0, 64'd0);
    sample();
    check("t1_b_rvalid",  {63'd0, b_if.rvalid}, 64'd1);
    check("t1_b_rdata",   b_if.rdata,           64'hDEAD_BEEF);
    check("t1_a_rvalid",  {63'd0, a_if.rvalid}, 64'd0);
    check("t1_a_rdata",   a_if.rdata,           64'd0);

    next_cycle();
    sample();
    check("t1_b_rvalid_end", {63'd0, b_if.rvalid}, 64'd0);
    check("t1_b_rdata_end",  b_if.rdata,           64'd0);

    // Continuous contention: 8 grants to A, 8 to B, 8 to A
    for (int i = 0; i < 24; i++) begin
      next_cycle();
      if (i == 0) begin
        drive_a(1'b1, 1'b0, 7'd1, 64'd0);
        drive_b(1'b1, 1'b0, 7'd2, 64'd0);
      end
      sample();
      exp_a = ((i / 8) % 2) == 0;
      check($sformatf("t2_a_gnt_%0d", i), {63'd0, a_if.gnt}, {63'd0, exp_a});
      check($sformatf("t2_b_gnt_%0d", i), {63'd0, b_if.gnt}, {63'd0, ~exp_a});
      if (i > 0) check($sformatf("t2_a_rvalid_%0d", i), {63'd0, a_if.rvalid}, {63'd0, prev_a});
      prev_a = exp_a;
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    drive_b(1'b0, 1'b0, 7'd0, 64'd0);
    sample();
    check("t2_a_rvalid_last", {63'd0, a_if.rvalid}, 64'd1);
    check("t2_b_rvalid_last", {63'd0, b_if.rvalid}, 64'd0);

    // Uncontended A: 20 writes then 20 back-to-back reads
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive_a(1'b1, 1'b1, ADDR_W'(i), pat(i));
      sample();
      check($sformatf("t3_wr_gnt_%0d", i), {63'd0, a_if.gnt}, 64'd1);
    end
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive_a(1'b1, 1'b0, ADDR_W'(i), 64'd0);
      sample();
      check($sformatf("t3_rd_gnt_%0d", i), {63'd0, a_if.gnt}, 64'd1);
      if (i == 0) begin
        check("t3_rvalid_0", {63'd0, a_if.rvalid}, 64'd0);
      end else begin
        check($sformatf("t3_rvalid_%0d", i), {63'd0, a_if.rvalid}, 64'd1);
        check($sformatf("t3_rdata_%0d", i),  a_if.rdata,           pat(i - 1));
      end
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    sample();
    check("t3_rvalid_20", {63'd0, a_if.rvalid}, 64'd1);
    check("t3_rdata_20",  a_if.rdata,           pat(19));
    next_cycle();
    sample();
    check("t3_rvalid_off", {63'd0, a_if.rvalid}, 64'd0);

    // A drops mid-tenure: B takes over the same cycle with a fresh burst of 8
    next_cycle();
    drive_a(1'b1, 1'b1, 7'd40, 64'h40);
    sample();
    check("t4_a_gnt_0", {63'd0, a_if.gnt}, 64'd1);
    for (int k = 1; k < 3; k++) begin
      next_cycle();
      drive_b(1'b1, 1'b1, 7'd41, 64'h41);
      sample();
      check($sformatf("t4_a_gnt_%0d", k), {63'd0, a_if.gnt}, 64'd1);
      check($sformatf("t4_b_wait_%0d", k), {63'd0, b_if.gnt}, 64'd0);
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    sample();
    check("t4_b_takeover", {63'd0, b_if.gnt}, 64'd1);
    check("t4_a_dropped",  {63'd0, a_if.gnt}, 64'd0);
    for (int k = 4; k < 11; k++) begin
      next_cycle();
      drive_a(1'b1, 1'b1, 7'd40, 64'h40);
      sample();
      check($sformatf("t4_b_gnt_%0d", k), {63'd0, b_if.gnt}, 64'd1);
      check($sformatf("t4_a_wait_%0d", k), {63'd0, a_if.gnt}, 64'd0);
    end
    next_cycle();
    sample();
    check("t4_a_regains", {63'd0, a_if.gnt}, 64'd1);
    check("t4_b_yields",  {63'd0, b_if.gnt}, 64'd0);
    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    drive_b(1'b0, 1'b0, 7'd0, 64'd0);
    sample();

    // Reset right after a B read grant discards the return
    next_cycle();
    drive_b(1'b1, 1'b0, 7'd5, 64'd0);
    sample();
    check("t5_b_gnt", {63'd0, b_if.gnt}, 64'd1);
    next_cycle();
    rst_n = 1'b0;
    drive_b(1'b0, 1'b0, 7'd0, 64'd0);
    sample();
    check("t5_b_rvalid_rst", {63'd0, b_if.rvalid}, 64'd0);
    check("t5_b_rdata_rst",  b_if.rdata,           64'd0);
    check("t5_ram_rd_rst",   {63'd0, ram_rd},      64'd0);
    next_cycle();
    sample();
    rst_n = 1'b1;
    next_cycle();
    sample();
    check("t5_post_a_gnt",    {63'd0, a_if.gnt},    64'd0);
    check("t5_post_b_gnt",    {63'd0, b_if.gnt},    64'd0);
    check("t5_post_a_rvalid", {63'd0, a_if.rvalid}, 64'd0);
    check("t5_post_b_rvalid", {63'd0, b_if.rvalid}, 64'd0);
    check("t5_post_a_rdata",  a_if.rdata,           64'd0);
    check("t5_post_b_rdata",  b_if.rdata,           64'd0);
    check("t5_post_ram_wr",   {63'd0, ram_wr},      64'd0);
    check("t5_post_ram_rd",   {63'd0, ram_rd},      64'd0);
    check("t5_post_ram_addr", {57'd0, ram_addr},    64'd0);
    next_cycle();
    drive_a(1'b1, 1'b0, 7'd3, 64'd0);
    drive_b(1'b1, 1'b0, 7'd4, 64'd0);
    sample();
    check("t5_tie_a_wins", {63'd0, a_if.gnt}, 64'd1);
    check("t5_tie_b_lose", {63'd0, b_if.gnt}, 64'd0);

    // Read-after-write: B writes 7 = 1, A reads 7 the next cycle
    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    drive_b(1'b1, 1'b1, 7'd7, 64'd1);
    sample();
    check("t6_b_gnt",     {63'd0, b_if.gnt}, 64'd1);
    check("t6_ram_wr",    {63'd0, ram_wr},   64'd1);
    check("t6_ram_rd_lo", {63'd0, ram_rd},   64'd0);
    check("t6_ram_addr",  {57'd0, ram_addr}, 64'd7);
    next_cycle();
    drive_b(1'b0, 1'b0, 7'd0, 64'd0);
    drive_a(1'b1, 1'b0, 7'd7, 64'd0);
    sample();
    check("t6_a_gnt",     {63'd0, a_if.gnt}, 64'd1);
    check("t6_ram_rd",    {63'd0, ram_rd},   64'd1);
    check("t6_ram_wr_lo", {63'd0, ram_wr},   64'd0);
    check("t6_b_no_rv",   {63'd0, b_if.rvalid}, 64'd0);
    next_cycle();
    drive_a(1'b0, 1'b0, 7'd0, 64'd0);
    sample();
    check("t6_a_rvalid",  {63'd0, a_if.rvalid}, 64'd1);
    check("t6_a_rdata",   a_if.rdata,           64'd1);
    check("t6_b_rvalid",  {63'd0, b_if.rvalid}, 64'd0);
    next_cycle();
    sample();
    check("t6_a_rvalid_off", {63'd0, a_if.rvalid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port BAND x DEPTH synchronous RAM between two requesters: port A (pixel ingest, mostly writes) and port B (filter fetch, mostly reads).
- Round-robin arbitration with a bounded burst tenure, so a streaming requester cannot starve the other.
- Drives the RAM's wr/rd/addr/data_in and returns read data to the winning port, tagged with a valid strobe one cycle after the granted read.
- Sits between the capture/filter pipelines and the frame/line RAM instance.

Parameters:
- BAND, 64, data word width in bits.
- DEPTH, 128, RAM word count.
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).
- MAX_BURST, 8, maximum consecutive grants to one port while the other port is requesting; legal range >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req  in  1  port A access request; held until granted.
- a_we  in  1  port A access type: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  BAND  port A write data.
- a_gnt  out  1  port A access accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  BAND  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_wr  out  1  RAM write enable.
- ram_rd  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  BAND  RAM write data.
- ram_rdata  in  BAND  RAM registered read data (valid the cycle after ram_rd; RAM drives 0 after idle cycles).

Behaviour:
- Transfer: occurs in any cycle where x_req && x_gnt. At most one gnt is high per cycle. A gnt is never high without its req.
- RAM drive (combinational from sel):
  - ram_wr = sel_we; ram_rd = !sel_we.
  - ram_addr and ram_wdata are muxed from the selected port.
  - With no selection: ram_wr = ram_rd = 0, and ram_addr/ram_wdata = 0.
  - ram_wr and ram_rd are never both high.
- Read return:
  - A port is granted a read in cycle t. In cycle t+1, x_rvalid = 1 and x_rdata = ram_rdata, passed through.
  - rvalid comes from a 2-bit registered read-owner flag; x_rdata = 0 when !x_rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads give rvalid every cycle.
- Read-after-write: the same address written at t and read at t+1 returns the new data at t+2.
- Registered state: owner {NONE, A, B}, burst_cnt (width $clog2(MAX_BURST+1)), last {A, B}.
- Selection (combinational, from state and current reqs):
  - owner = X, x_req = 1, and (burst_cnt < MAX_BURST or other req = 0): sel = X.
  - Else if other req = 1: sel = other.
  - Else if x_req = 1: sel = X.
  - owner = NONE, both reqs high: sel = port != last.
  - owner = NONE, one req high: sel = that port.
  - Otherwise: sel = NONE.
- Update each edge:
  - owner <= sel.
  - burst_cnt <= 0 if sel = NONE.
  - burst_cnt <= sat(burst_cnt + 1, MAX_BURST) if sel = owner.
  - burst_cnt <= 1 on a handover.
  - last <= sel when sel != NONE.
- Result under contention: exactly MAX_BURST consecutive grants, then a forced handover. An uncontended port is granted every cycle indefinitely.
- Request drop: if a port drops req mid-tenure, it loses ownership the same cycle.
- Reset values:
  - owner = NONE, burst_cnt = 0, last = B, so A wins the first tie.
  - Read-owner flag cleared.
  - All gnt and rvalid outputs = 0; all rdata outputs = 0; ram_wr = ram_rd = 0.
- Reset mid-operation: a pending read return is discarded; no rvalid follows reset deassertion.
- Address range: addresses >= DEPTH are passed unchanged; range checking is the requester's responsibility.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_A, OWN_B}.
  - Localparam function for burst_cnt width.
  - Struct for a port's request bundle (req, we, addr, wdata), parameterised by ADDR_W/BAND via the package's defaults.
- Sub-module: one, rr_burst_sel, holding the owner/burst_cnt/last registers and the selection logic. The top level adds the RAM muxing and read-return pipeline.

Test Plan:
- Reset, then A write addr 5 = 64'hDEAD_BEEF, then B read addr 5 -> ram_wr at t0, b_gnt at t1, b_rvalid at t2 with b_rdata = 64'hDEAD_BEEF; a_rvalid stays 0.
- Both req held high continuously, MAX_BURST = 8 -> a_gnt for cycles 0-7, b_gnt for 8-15, a_gnt for 16-23; never two grants in one cycle.
- A alone requests reads at addrs 0..19 -> a_gnt for all 20 consecutive cycles; a_rvalid 20 consecutive cycles, one cycle delayed, with matching data.
- A holds for 3 grants then drops req while B requests -> B granted the same cycle A drops; B's burst_cnt starts at 1.
- rst_n asserted the cycle after a B read grant -> b_rvalid never asserts; after release all outputs are 0 and A wins the first simultaneous request.
- B writes addr 7 = 1 at t, A reads addr 7 at t+1 -> a_rvalid at t+2 with a_rdata = 1; ram_wr and ram_rd are never high together.
